// File: rtl/game_timer_gen.sv
// Game-pacing timer: divides clk into a programmable half-period toggle plus tick,
// counts half-periods, stops on limit or error. Optional runtime period load: GAME_TIMER_PERIOD_LD_EN.
module game_timer_gen #(
  parameter int HALF_PERIOD = 75000000,
  parameter int CNT_W       = 32,
  parameter int MAX_HALVES  = 30,
  parameter int IDX_W       = 5,
  parameter int ERR_W       = 3,
  parameter int ERR_LIMIT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [ERR_W-1:0] wrong_time,
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_ld,
  output logic             clk_out,
  output logic             tick,
  output logic [IDX_W-1:0] half_cnt,
  output logic             running,
  output logic             done,
  output logic             done_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_eff;
  logic             err_hit;
  logic             wrap;
  logic             last_half;

  assign err_hit    = wrong_time >= ERR_W'(ERR_LIMIT);
  assign period_eff = (period == '0) ? CNT_W'(1) : period;
  assign wrap       = (cnt == period_eff - CNT_W'(1));
  assign last_half  = (half_cnt + IDX_W'(1)) == IDX_W'(MAX_HALVES);

`ifdef GAME_TIMER_PERIOD_LD_EN
  logic [CNT_W-1:0] period_pend;

  // While counting, a new period waits in period_pend and takes over at the next wrap
  // so the half-period in flight keeps its original length.
  always_ff @(posedge clk) begin
    if (rst) begin
      period      <= CNT_W'(HALF_PERIOD);
      period_pend <= CNT_W'(HALF_PERIOD);
    end else begin
      if (period_ld) begin
        period_pend <= period_in;
      end
      if (period_ld && (restart || state == IDLE || state == DONE)) begin
        period <= period_in;
      end else if (!restart && state == RUN && !err_hit && wrap) begin
        period <= period_pend;
      end
    end
  end
`else
  logic unused_period;
  assign unused_period = ^{period_in, period_ld};
  assign period        = CNT_W'(HALF_PERIOD);
`endif

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state    <= IDLE;
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      half_cnt <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            if (err_hit) begin
              state    <= DONE;
              done     <= 1'b1;
              done_err <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          // Error takes priority over a coincident wrap: nothing advances.
          if (err_hit) begin
            state    <= DONE;
            cnt      <= '0;
            running  <= 1'b0;
            done     <= 1'b1;
            done_err <= 1'b1;
          end else begin
            if (wrap) begin
              cnt      <= '0;
              clk_out  <= ~clk_out;
              tick     <= 1'b1;
              half_cnt <= half_cnt + IDX_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            if (wrap && last_half) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (!en) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (err_hit) begin
            state    <= DONE;
            cnt      <= '0;
            done     <= 1'b1;
            done_err <= 1'b1;
          end else if (en) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer_gen.sv
// Bench for game_timer_gen: directed scenarios plus random stimulus against a
// behavioural model of elapsed run cycles per half-period.
module tb_game_timer_gen;

  localparam int HP    = 4;
  localparam int MH    = 3;
  localparam int EL    = 3;
  localparam int CNT_W = 32;
  localparam int IDX_W = 5;
  localparam int ERR_W = 3;
`ifdef GAME_TIMER_PERIOD_LD_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             restart;
  logic [ERR_W-1:0] wrong_time;
  logic [CNT_W-1:0] period_in;
  logic             period_ld;
  logic             clk_out;
  logic             tick;
  logic [IDX_W-1:0] half_cnt;
  logic             running;
  logic             done;
  logic             done_err;

  game_timer_gen #(
    .HALF_PERIOD(HP),
    .CNT_W(CNT_W),
    .MAX_HALVES(MH),
    .IDX_W(IDX_W),
    .ERR_W(ERR_W),
    .ERR_LIMIT(EL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .restart(restart),
    .wrong_time(wrong_time),
    .period_in(period_in),
    .period_ld(period_ld),
    .clk_out(clk_out),
    .tick(tick),
    .half_cnt(half_cnt),
    .running(running),
    .done(done),
    .done_err(done_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  int m_mode    = M_IDLE;
  int m_elapsed = 0;
  int m_halves  = 0;
  int m_period  = HP;
  int m_pend    = HP;
  bit m_level   = 1'b0;
  bit m_tick    = 1'b0;
  bit m_err     = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int p        = (m_period == 0) ? 1 : m_period;
    int old_pend = m_pend;
    bit err      = int'(wrong_time) >= EL;
    if (rst || restart) begin
      if (rst) begin
        m_period = HP;
        m_pend   = HP;
      end else if (FEAT && period_ld) begin
        m_period = int'(period_in);
        m_pend   = int'(period_in);
      end
      m_mode = M_IDLE; m_elapsed = 0; m_halves = 0;
      m_level = 1'b0; m_tick = 1'b0; m_err = 1'b0;
      return;
    end
    m_tick = 1'b0;
    if (FEAT && period_ld) begin
      m_pend = int'(period_in);
      if (m_mode == M_IDLE || m_mode == M_DONE) m_period = int'(period_in);
    end
    case (m_mode)
      M_IDLE: if (en) begin
        if (err) begin m_mode = M_DONE; m_err = 1'b1; end
        else m_mode = M_RUN;
      end
      M_RUN: begin
        if (err) begin
          m_mode = M_DONE; m_err = 1'b1; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed >= p) begin
            m_elapsed = 0;
            m_level   = !m_level;
            m_tick    = 1'b1;
            m_halves++;
            m_period  = old_pend;
          end
          if (m_tick && m_halves == MH) m_mode = M_DONE;
          else if (!en) m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (err) begin m_mode = M_DONE; m_err = 1'b1; end
        else if (en) m_mode = M_RUN;
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".clk_out"},  clk_out,  m_level);
    check({tag, ".tick"},     tick,     m_tick);
    check({tag, ".half_cnt"}, half_cnt, m_halves);
    check({tag, ".running"},  running,  m_mode == M_RUN);
    check({tag, ".done"},     done,     m_mode == M_DONE);
    check({tag, ".done_err"}, done_err, m_err);
  endtask

  task automatic run_until_tick(input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(tag);
      if (tick) begin
        n = i;
        break;
      end
    end
    if (n < 0) check({tag, ".tick_seen"}, tick, 1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cycle("restart");
    restart = 1'b0;
  endtask

  int t1, t2, t3, lat;

  initial begin
    rst = 1'b1; en = 1'b0; restart = 1'b0; wrong_time = '0;
    period_in = '0; period_ld = 1'b0;
    cycle("reset");
    cycle("reset");
    check("reset.half_cnt", half_cnt, 0);
    check("reset.clk_out", clk_out, 0);

    // Free run to the half-period limit.
    rst = 1'b0; en = 1'b1;
    run_until_tick("s1", t1);
    check("s1.first_latency", t1, 5);
    for (int i = 0; i < 8; i++) cycle("s1");
    check("s1.done", done, 1);
    check("s1.done_err", done_err, 0);
    check("s1.half_cnt", half_cnt, MH);
    for (int i = 0; i < 4; i++) cycle("s1.hold");
    check("s1.frozen_clk", clk_out, 1);

    // Restart from DONE with en held.
    do_restart();
    check("rs.half_cnt", half_cnt, 0);
    check("rs.done", done, 0);
    run_until_tick("rs", t2);
    check("rs.latency", t2, t1);

    // Pause: first toggle slips by exactly the pause length.
    en = 1'b0;
    do_restart();
    en = 1'b1;
    lat = 0;
    for (int i = 0; i < 3; i++) begin cycle("pz"); lat++; end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("pz");
      lat++;
      check("pz.running", running, 0);
    end
    en = 1'b1;
    run_until_tick("pz", t3);
    check("pz.latency", lat + t3, t1 + 5);

    // Error on a wrap cycle wins.
    do_restart();
    run_until_tick("ew", t3);
    for (int i = 0; i < 3; i++) cycle("ew");
    wrong_time = ERR_W'(EL);
    cycle("ew");
    wrong_time = '0;
    check("ew.clk_out", clk_out, 1);
    check("ew.half_cnt", half_cnt, 1);
    check("ew.tick", tick, 0);
    check("ew.done_err", done_err, 1);

    // Reset mid-run with clk_out high.
    do_restart();
    run_until_tick("mr", t3);
    cycle("mr");
    rst = 1'b1;
    cycle("mr.rst");
    rst = 1'b0;
    check("mr.clk_out", clk_out, 0);
    check("mr.running", running, 0);

`ifdef GAME_TIMER_PERIOD_LD_EN
    do_restart();
    cycle("ld");
    cycle("ld");
    period_ld = 1'b1; period_in = 2;
    cycle("ld");
    period_ld = 1'b0;
    run_until_tick("ld", t3);
    check("ld.old_len", t3, 2);
    run_until_tick("ld", t3);
    check("ld.new_len", t3, 2);
    restart = 1'b1; period_ld = 1'b1; period_in = 0;
    cycle("ld0");
    restart = 1'b0; period_ld = 1'b0;
    run_until_tick("ld0", t3);
    check("ld0.first", t3, 2);
    run_until_tick("ld0", t3);
    check("ld0.every", t3, 1);
    restart = 1'b1; period_ld = 1'b1; period_in = HP;
    cycle("ld");
    restart = 1'b0; period_ld = 1'b0;
`endif

    // Random stimulus.
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(199, 0) == 0);
      restart    = ($urandom_range(39, 0) == 0);
      en         = ($urandom_range(9, 0) < 8);
      wrong_time = ($urandom_range(19, 0) == 0) ? ERR_W'($urandom_range(7, EL))
                                                : ERR_W'($urandom_range(EL - 1, 0));
      period_ld  = ($urandom_range(19, 0) == 0);
      period_in  = CNT_W'($urandom_range(5, 0));
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
